iir_stream_capture: RTL and testbench

Output-side capture buffer for the cascaded-SOS filter chain. It takes the filter's free-running `dv`/18-bit sample stream, which has no backpressure, and stores the samples in a FIFO. Each sample is tagged with a frame-boundary flag. The samples are then presented to a downstream consumer over a valid/ready handshake. Samples lost to a full buffer are recorded in a sticky overflow flag and a saturating drop counter.

---
 rtl/iir_stream_capture.sv | 125 ++++++++++++
 tb/tb_iir_stream_capture.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/iir_stream_capture.sv
// iir_stream_capture
// Capture buffer behind the cascaded-SOS filter chain. The filter's free-running
// dv/sample stream has no backpressure. Each sample is tagged with a
// frame-boundary flag and queued in a FIFO. The FIFO is drained by a consumer
// over a valid/ready handshake. A sample that arrives while the buffer is full
// is lost. Each loss sets a sticky overflow flag and bumps a saturating drop
// counter.
module iir_stream_capture #(
   parameter int DEPTH     = 16,
   parameter int FRAME_LEN = 8,
   parameter int W         = 18
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     dv_in,
   input  logic [W-1:0]             d_in,
   output logic                     m_valid,
   output logic [W-1:0]             m_data,
   output logic                     m_last,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [15:0]              drop_cnt,
   input  logic                     ovf_clr
);

   localparam int AW  = $clog2(DEPTH);
   localparam int FCW = $clog2(FRAME_LEN);
   localparam logic [AW:0]    FULL_LEVEL = (AW+1)'(DEPTH);
   localparam logic [FCW-1:0] LAST_IDX   = FCW'(FRAME_LEN - 1);

   logic [W:0]     mem_q [DEPTH];
   logic [AW-1:0]  wrPtr_q, wrPtr_d;
   logic [AW-1:0]  rdPtr_q, rdPtr_d;
   logic [AW:0]    level_q, level_d;
   logic [FCW-1:0] frameCnt_q, frameCnt_d;
   logic           overflow_q, overflow_d;
   logic [15:0]    dropCnt_q, dropCnt_d;

   logic isFull, isEmpty, writeEn, dropEn, readEn, frameLast;
   logic [W:0] headEntry;

   // Fullness is judged on the registered level, so a read in the same cycle
   // cannot make room for an incoming sample.
   assign isFull    = (level_q == FULL_LEVEL);
   assign isEmpty   = (level_q == '0);
   assign writeEn   = dv_in && !isFull;
   assign dropEn    = dv_in && isFull;
   assign readEn    = !isEmpty && m_ready;
   assign frameLast = (frameCnt_q == LAST_IDX);

   // Next-state for pointers, fill level, frame position and overflow status
   always_comb begin
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      level_d    = level_q;
      frameCnt_d = frameCnt_q;
      overflow_d = overflow_q;
      dropCnt_d  = dropCnt_q;

      if (writeEn) begin
         wrPtr_d    = wrPtr_q + AW'(1);
         frameCnt_d = frameLast ? '0 : frameCnt_q + FCW'(1);
      end

      if (readEn) begin
         rdPtr_d = rdPtr_q + AW'(1);
      end

      case ({writeEn, readEn})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase

      if (dropEn) begin
         overflow_d = 1'b1;
         if (ovf_clr) begin
            dropCnt_d = 16'd1;
         end else if (dropCnt_q != 16'hFFFF) begin
            dropCnt_d = dropCnt_q + 16'd1;
         end
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
         dropCnt_d  = 16'd0;
      end
   end

   // Control state register, cleared asynchronously so outputs drop at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         level_q    <= '0;
         frameCnt_q <= '0;
         overflow_q <= 1'b0;
         dropCnt_q  <= 16'd0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         level_q    <= level_d;
         frameCnt_q <= frameCnt_d;
         overflow_q <= overflow_d;
         dropCnt_q  <= dropCnt_d;
      end
   end

   // Sample storage {last, data}; contents survive reset, only pointers clear
   always_ff @(posedge clk) begin
      if (writeEn) begin
         mem_q[wrPtr_q] <= {frameLast, d_in};
      end
   end

   // Head presentation derives only from registered state, so outputs hold
   // steady under backpressure and read as zero when the buffer is empty.
   assign headEntry = mem_q[rdPtr_q];
   assign m_valid   = !isEmpty;
   assign m_data    = m_valid ? headEntry[W-1:0] : '0;
   assign m_last    = m_valid & headEntry[W];
   assign level     = level_q;
   assign overflow  = overflow_q;
   assign drop_cnt  = dropCnt_q;

endmodule

// File: tb/tb_iir_stream_capture.sv
// Testbench for iir_stream_capture: directed stimulus, with a scoreboard queue
// drained by an independent monitor on every handshake transfer.
module tb_iir_stream_capture;

   localparam int DEPTH     = 16;
   localparam int FRAME_LEN = 8;
   localparam int W         = 18;
   localparam int LW        = $clog2(DEPTH) + 1;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b1;
   logic          dv_in    = 1'b0;
   logic [W-1:0]  d_in     = '0;
   logic          m_ready  = 1'b0;
   logic          ovf_clr  = 1'b0;
   logic          m_valid;
   logic [W-1:0]  m_data;
   logic          m_last;
   logic [LW-1:0] level;
   logic          overflow;
   logic [15:0]   drop_cnt;

   int testsRun    = 0;
   int testsFailed = 0;
   logic [W:0] expQ [$];

   iir_stream_capture #(
      .DEPTH(DEPTH),
      .FRAME_LEN(FRAME_LEN),
      .W(W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .dv_in(dv_in),
      .d_in(d_in),
      .m_valid(m_valid),
      .m_data(m_data),
      .m_last(m_last),
      .m_ready(m_ready),
      .level(level),
      .overflow(overflow),
      .drop_cnt(drop_cnt),
      .ovf_clr(ovf_clr)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of inputs, let the edge happen, then release the strobes
   task automatic applyStimulus(input logic dv, input int d, input logic ready, input logic clr);
      dv_in   = dv;
      d_in    = W'(d);
      m_ready = ready;
      ovf_clr = clr;
      tick();
      dv_in   = 1'b0;
      ovf_clr = 1'b0;
   endtask

   task automatic pushExp(input int d, input logic last);
      expQ.push_back({last, W'(d)});
   endtask

   task automatic waitDrain(input string name);
      m_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (level == '0 && expQ.size() == 0) break;
         tick();
      end
      checkOutput({name, " drained level"}, 32'(level), 0);
      checkOutput({name, " drained queue"}, 32'(expQ.size()), 0);
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, " m_valid"},  32'(m_valid),  0);
      checkOutput({name, " m_data"},   32'(m_data),   0);
      checkOutput({name, " m_last"},   32'(m_last),   0);
      checkOutput({name, " level"},    32'(level),    0);
      checkOutput({name, " overflow"}, 32'(overflow), 0);
      checkOutput({name, " drop_cnt"}, 32'(drop_cnt), 0);
   endtask

   task automatic doReset(input string name);
      dv_in   = 1'b0;
      ovf_clr = 1'b0;
      m_ready = 1'b0;
      rst_n   = 1'b0;
      #1;
      checkAllZero(name);
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Monitor: every accepted transfer must match the oldest expected sample
   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected transfer", 32'({m_last, m_data}), 32'h7FFFFFFF);
         end else begin
            checkOutput("scoreboard sample", 32'({m_last, m_data}), 32'(expQ.pop_front()));
         end
      end
   end

   // Watchdog so the bench always terminates
   initial begin
      #100000;
      $display("[TB] FAIL watchdog timeout: got running, expected finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      #1;
      doReset("reset");

      // Five single samples, each visible one cycle after its write
      for (int i = 1; i <= 5; i++) begin
         pushExp(i, 1'b0);
         applyStimulus(1'b1, i, 1'b1, 1'b0);
         checkOutput("t1 valid after write", 32'(m_valid), 1);
         checkOutput("t1 head data", 32'(m_data), 32'(i));
         checkOutput("t1 level", 32'(level), 1);
         tick();
      end
      waitDrain("t1");

      // Back-to-back stream of 20 samples, frame flags on the 8th and 16th
      doReset("t2 reset");
      for (int i = 0; i < 20; i++) begin
         pushExp(32'h10 + i, (i % FRAME_LEN) == FRAME_LEN - 1);
         applyStimulus(1'b1, 32'h10 + i, 1'b1, 1'b0);
      end
      checkOutput("t2 streaming level", 32'(level), 1);
      waitDrain("t2");

      // Fill past capacity with the consumer stalled: two drops
      doReset("t3 reset");
      for (int i = 0; i < 18; i++) begin
         if (i < DEPTH) pushExp(32'h100 + i, (i % FRAME_LEN) == FRAME_LEN - 1);
         applyStimulus(1'b1, 32'h100 + i, 1'b0, 1'b0);
      end
      checkOutput("t3 level full", 32'(level), 16);
      checkOutput("t3 overflow", 32'(overflow), 1);
      checkOutput("t3 drop_cnt", 32'(drop_cnt), 2);
      checkOutput("t3 head held", 32'(m_data), 32'h100);

      // Clear coinciding with a drop: the drop wins
      applyStimulus(1'b1, 32'h3FFFF, 1'b0, 1'b1);
      checkOutput("t5 clr+drop overflow", 32'(overflow), 1);
      checkOutput("t5 clr+drop drop_cnt", 32'(drop_cnt), 1);
      checkOutput("t5 clr+drop level", 32'(level), 16);

      // Clear on its own
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
      checkOutput("t5 clr overflow", 32'(overflow), 0);
      checkOutput("t5 clr drop_cnt", 32'(drop_cnt), 0);
      checkOutput("t5 clr level", 32'(level), 16);

      // Full with a simultaneous write and read: write dropped, read completes
      applyStimulus(1'b1, 32'h2AAAA, 1'b1, 1'b0);
      checkOutput("t4 level", 32'(level), 15);
      checkOutput("t4 drop_cnt", 32'(drop_cnt), 1);
      checkOutput("t4 overflow", 32'(overflow), 1);
      checkOutput("t4 next head", 32'(m_data), 32'h101);
      waitDrain("t4");

      // Drops must not have advanced the frame counter
      for (int i = 0; i < FRAME_LEN; i++) begin
         pushExp(32'h200 + i, i == FRAME_LEN - 1);
         applyStimulus(1'b1, 32'h200 + i, 1'b1, 1'b0);
      end
      waitDrain("frame after drops");

      // Asynchronous reset mid-frame with samples buffered
      doReset("t6 reset");
      for (int i = 0; i < 4; i++) begin
         pushExp(32'h300 + i, 1'b0);
         applyStimulus(1'b1, 32'h300 + i, 1'b1, 1'b0);
      end
      waitDrain("t6 pre");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, 32'h310 + i, 1'b0, 1'b0);
      end
      checkOutput("t6 level before reset", 32'(level), 7);
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("t6 async reset");
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < FRAME_LEN; i++) begin
         pushExp(32'h400 + i, i == FRAME_LEN - 1);
         applyStimulus(1'b1, 32'h400 + i, 1'b1, 1'b0);
      end
      waitDrain("t6 post");

      checkOutput("final queue empty", 32'(expQ.size()), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
